// File: rtl/lsu_gen_pkg.sv
// Shared types for the load/store unit: access sizes and controller states.
package lsu_gen_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10,
    LSU_DBL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_BEAT1 = 2'b01,
    LSU_BEAT2 = 2'b10,
    LSU_RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_gen_align.sv
// Combinational data path of the LSU: access classification, per-beat byte masks,
// store data rotation and load merge/extension.
module lsu_gen_align
  import lsu_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [1:0]                size_i,
  input  logic                      sign_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           beat1_i,
  input  logic [XLEN-1:0]           beat2_i,
  output logic                      misalign_o,
  output logic                      illegal_o,
  output logic [XLEN/8-1:0]         mask1_o,
  output logic [XLEN/8-1:0]         mask2_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           rdata_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  logic [4:0]        len;
  logic [2*NB-1:0]   lmask;
  logic [2*NB-1:0]   smask;
  logic [OW+2:0]     shamt;
  logic [XLEN-1:0]   merged;
  logic              sbit;

  assign len        = 5'd1 << size_i;
  assign shamt      = {off_i, 3'b000};
  assign illegal_o  = (size_i == LSU_DBL) && (XLEN == 32);
  assign misalign_o = (5'(off_i) + len) > 5'(NB);

  always_comb begin
    lmask = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      lmask[i] = 5'(i) < len;
    end
  end

  assign smask   = lmask << off_i;
  assign mask1_o = smask[NB-1:0];
  assign mask2_o = smask[2*NB-1:NB];

  // Rotate rather than shift so the bytes that spill past the beat land in beat 2's lanes.
  assign wdata_o = (wdata_i << shamt) | (wdata_i >> (XLEN - 32'(shamt)));

  assign merged = XLEN'({beat2_i, beat1_i} >> shamt);

  always_comb begin
    sbit = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (5'(b) + 5'd1 == len) sbit = sign_i & merged[8*b+7];
    end
    rdata_o = '0;
    for (int b = 0; b < NB; b++) begin
      rdata_o[8*b+:8] = (5'(b) < len) ? merged[8*b+:8] : {8{sbit}};
    end
  end

endmodule

// File: rtl/lsu_gen.sv
// Load/store unit: captures one core request, issues one or two bus beats and
// returns a single completion pulse with extended load data or an error.
module lsu_gen
  import lsu_gen_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              is_write,
  input  logic [XLEN-1:0]   wdata,
  input  logic [31:0]       addr,
  input  logic [1:0]        data_size,
  input  logic              is_mem_sign,
  output logic              respValid,
  output logic              respErr,
  output logic [XLEN-1:0]   rdata,
  output logic              io_reqValid,
  input  logic              io_respValid,
  input  logic              io_respErr,
  output logic [31:0]       io_addr,
  output logic [1:0]        io_size,
  output logic              io_wen,
  output logic [XLEN-1:0]   io_wdata,
  output logic [XLEN/8-1:0] io_wmask,
  input  logic [XLEN-1:0]   io_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic [31:0]     addr_q;
  logic [1:0]      size_q;
  logic            wr_q;
  logic            sign_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rbuf_q, rbuf_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            idle;
  logic            busy;
  logic [OW-1:0]   a_off;
  logic [1:0]      a_size;
  logic [XLEN-1:0] beat1;
  logic [XLEN-1:0] beat2;
  logic            misalign;
  logic            illegal;
  logic [NB-1:0]   mask1;
  logic [NB-1:0]   mask2;
  logic [XLEN-1:0] rot_wdata;
  logic [XLEN-1:0] ld_data;
  logic [31:0]     beat2_addr;

  assign idle = (state_q == LSU_IDLE);
  assign busy = (state_q == LSU_BEAT1) || (state_q == LSU_BEAT2);

  // In IDLE the aligner classifies the incoming request so it can be rejected on accept.
  assign a_off  = idle ? addr[OW-1:0] : addr_q[OW-1:0];
  assign a_size = idle ? data_size : size_q;
  assign beat1  = (state_q == LSU_BEAT1) ? io_rdata : rbuf_q;
  assign beat2  = (state_q == LSU_BEAT2) ? io_rdata : '0;

  assign beat2_addr = {addr_q[31:OW] + (32 - OW)'(1), {OW{1'b0}}};

  lsu_gen_align #(
    .XLEN (XLEN)
  ) u_align (
    .off_i      (a_off),
    .size_i     (a_size),
    .sign_i     (sign_q),
    .wdata_i    (wdata_q),
    .beat1_i    (beat1),
    .beat2_i    (beat2),
    .misalign_o (misalign),
    .illegal_o  (illegal),
    .mask1_o    (mask1),
    .mask2_o    (mask2),
    .wdata_o    (rot_wdata),
    .rdata_o    (ld_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
    end else if (idle && reqValid) begin
      addr_q  <= addr;
      size_q  <= data_size;
      wr_q    <= is_write;
      sign_q  <= is_mem_sign;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LSU_IDLE;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (reqValid) begin
          rdata_d = '0;
          if (illegal || (misalign && (MISALIGN_SPLIT == 0))) begin
            err_d   = 1'b1;
            state_d = LSU_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = LSU_BEAT1;
          end
        end
      end
      LSU_BEAT1: begin
        if (io_respValid) begin
          rbuf_d = io_rdata;
          if (io_respErr) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = LSU_RESP;
          end else if (misalign) begin
            state_d = LSU_BEAT2;
          end else begin
            rdata_d = wr_q ? '0 : ld_data;
            state_d = LSU_RESP;
          end
        end
      end
      LSU_BEAT2: begin
        if (io_respValid) begin
          err_d   = io_respErr;
          rdata_d = (io_respErr || wr_q) ? '0 : ld_data;
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside a beat so idle/reset values are clean.
  always_comb begin
    reqReady    = idle;
    respValid   = (state_q == LSU_RESP);
    respErr     = respValid & err_q;
    rdata       = respValid ? rdata_q : '0;
    io_reqValid = 1'b0;
    io_addr     = '0;
    io_size     = '0;
    io_wen      = 1'b0;
    io_wdata    = '0;
    io_wmask    = '0;
    if (busy) begin
      io_reqValid = 1'b1;
      io_size     = size_q;
      io_wen      = wr_q;
      io_wdata    = rot_wdata;
      io_addr     = (state_q == LSU_BEAT1) ? addr_q : beat2_addr;
      io_wmask    = (state_q == LSU_BEAT1) ? mask1 : mask2;
    end
  end

endmodule
